// File: rtl/runway_picker.sv
// ============================================================================
//  Module      : runway_picker
//  Description : Clears landing requests to runway A (N/S) or B (E/W). Each
//                runway has an occupancy timer, and one aircraft can wait in a
//                single hold slot while both runways are busy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module runway_picker #(
    parameter int OCC_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] d,
    input  logic       en,
    output logic       A,
    output logic       B,
    output logic [3:0] signal
);

    localparam int              c_TW  = $clog2(OCC_CYCLES + 1);
    localparam logic [c_TW-1:0] c_OCC = c_TW'(OCC_CYCLES);
    localparam logic [c_TW-1:0] c_ONE = c_TW'(1);

    logic [c_TW-1:0] r_timer_a, r_timer_b;
    logic            r_slot_valid;
    logic [1:0]      r_slot_d;
    logic [1:0]      r_clr;
    logic            r_reject;
    logic            r_a, r_b;

    logic            w_free_a, w_free_b;
    logic            w_sg_a, w_sg_b;
    logic            w_rg_a, w_rg_b;
    logic            w_left_a, w_left_b;
    logic            w_gnt_a, w_gnt_b;
    logic            w_slot_valid_nxt;
    logic [1:0]      w_slot_d_nxt;
    logic            w_reject;
    logic [c_TW-1:0] w_timer_a_nxt, w_timer_b_nxt;

    assign w_free_a = (r_timer_a == '0);
    assign w_free_b = (r_timer_b == '0);
    assign w_left_a = w_free_a & ~w_sg_a;
    assign w_left_b = w_free_b & ~w_sg_b;
    assign w_gnt_a  = w_sg_a | w_rg_a;
    assign w_gnt_b  = w_sg_b | w_rg_b;

    // Waiting aircraft is served before the new request.
    always_comb begin
        w_sg_a = 1'b0;
        w_sg_b = 1'b0;
        if (r_slot_valid) begin
            if (!r_slot_d[0]) begin
                if (w_free_a)      w_sg_a = 1'b1;
                else if (w_free_b) w_sg_b = 1'b1;
            end else begin
                if (w_free_b)      w_sg_b = 1'b1;
                else if (w_free_a) w_sg_a = 1'b1;
            end
        end
    end

    // A slot vacated this edge may immediately take the new request.
    always_comb begin
        w_rg_a           = 1'b0;
        w_rg_b           = 1'b0;
        w_reject         = 1'b0;
        w_slot_valid_nxt = r_slot_valid & ~(w_sg_a | w_sg_b);
        w_slot_d_nxt     = r_slot_d;
        if (en) begin
            if (!d[0]) begin
                if (w_left_a)      w_rg_a = 1'b1;
                else if (w_left_b) w_rg_b = 1'b1;
            end else begin
                if (w_left_b)      w_rg_b = 1'b1;
                else if (w_left_a) w_rg_a = 1'b1;
            end
            if (!w_left_a && !w_left_b) begin
                if (!w_slot_valid_nxt) begin
                    w_slot_valid_nxt = 1'b1;
                    w_slot_d_nxt     = d;
                end else begin
                    w_reject = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_timer_a_nxt = r_timer_a;
        w_timer_b_nxt = r_timer_b;
        if (w_gnt_a)       w_timer_a_nxt = c_OCC;
        else if (!w_free_a) w_timer_a_nxt = r_timer_a - c_ONE;
        if (w_gnt_b)       w_timer_b_nxt = c_OCC;
        else if (!w_free_b) w_timer_b_nxt = r_timer_b - c_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer_a    <= '0;
            r_timer_b    <= '0;
            r_slot_valid <= 1'b0;
            r_slot_d     <= 2'b00;
            r_clr        <= 2'b00;
            r_reject     <= 1'b0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
        end else begin
            r_timer_a    <= w_timer_a_nxt;
            r_timer_b    <= w_timer_b_nxt;
            r_slot_valid <= w_slot_valid_nxt;
            r_slot_d     <= w_slot_d_nxt;
            r_reject     <= w_reject;
            r_a          <= (w_timer_a_nxt != '0);
            r_b          <= (w_timer_b_nxt != '0);
            if (w_gnt_a || w_gnt_b)
                r_clr <= {w_gnt_b, w_gnt_a};
        end
    end

    assign A      = r_a;
    assign B      = r_b;
    assign signal = {r_reject, r_slot_valid, r_clr};

endmodule

`default_nettype wire

// File: tb/tb_runway_picker.sv
// ============================================================================
//  Module      : tb_runway_picker
//  Description : Directed and random stimulus for runway_picker, compared
//                every cycle against a runway-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_runway_picker;

    localparam int OCC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] d = 2'b00;
    logic       en = 1'b0;
    logic       A, B;
    logic [3:0] signal;

    int checks = 0;
    int failures = 0;

    runway_picker #(.OCC_CYCLES(OCC)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en),
        .A(A), .B(B), .signal(signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: runway index 0=A, 1=B; preferred runway is d[0].
    int       t[2];
    bit       slot_v;
    bit [1:0] slot_d;
    bit [1:0] last_clr;
    bit       rej;
    bit       mvalid = 1'b0;

    function automatic int pick(input int p, input bit fr[2], input bit g[2]);
        if (fr[p] && !g[p])         return p;
        if (fr[1-p] && !g[1-p])     return 1 - p;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            t[0] = 0; t[1] = 0;
            slot_v = 0; slot_d = 0; last_clr = 0; rej = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            bit fr[2];
            bit g[2];
            int r;
            fr[0] = (t[0] == 0); fr[1] = (t[1] == 0);
            g[0] = 0; g[1] = 0;
            rej = 0;
            if (slot_v) begin
                r = pick(int'(slot_d[0]), fr, g);
                if (r >= 0) begin g[r] = 1; slot_v = 0; end
            end
            if (en) begin
                r = pick(int'(d[0]), fr, g);
                if (r >= 0)       g[r] = 1;
                else if (!slot_v) begin slot_v = 1; slot_d = d; end
                else              rej = 1;
            end
            for (int i = 0; i < 2; i++)
                if (g[i]) t[i] = OCC; else if (t[i] > 0) t[i] = t[i] - 1;
            if (g[0] || g[1]) last_clr = {g[1], g[0]};
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_A", 32'(A), 32'(t[0] != 0));
            chk("model_B", 32'(B), 32'(t[1] != 0));
            chk("model_signal", 32'(signal), 32'({rej, slot_v, last_clr}));
        end
    end

    // Inputs change on the falling edge; returns after the next rising edge.
    task automatic cyc(input bit e, input bit [1:0] dd);
        en = e; d = dd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b1, 2'b00);
        cyc(1'b1, 2'b01);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_A", 32'(A), 32'd0);
        chk("reset_B", 32'(B), 32'd0);
        chk("reset_signal", 32'(signal), 32'h0);

        // Single north arrival occupies A for exactly OCC cycles.
        cyc(1'b1, 2'b00);
        chk("north_A", 32'(A), 32'd1);
        chk("north_signal", 32'(signal), 32'b0001);
        repeat (OCC - 1) cyc(1'b0, 2'b00);
        chk("A_still_busy", 32'(A), 32'd1);
        cyc(1'b0, 2'b00);
        chk("A_released", 32'(A), 32'd0);

        // Second north arrival while A busy goes to B.
        do_reset();
        cyc(1'b1, 2'b00);
        cyc(1'b0, 2'b00);
        cyc(1'b1, 2'b00);
        chk("overflow_B", 32'(B), 32'd1);
        chk("overflow_signal", 32'(signal), 32'b0010);

        // Hold slot fill, reject, then slot release to B plus refill.
        do_reset();
        cyc(1'b1, 2'b01);                 // edge1: B
        cyc(1'b1, 2'b00);                 // edge2: A
        cyc(1'b1, 2'b01);                 // edge3: held
        chk("hold_signal", 32'(signal), 32'b0101);
        cyc(1'b1, 2'b10);                 // edge4: rejected
        chk("reject_pulse", 32'(signal), 32'b1101);
        cyc(1'b0, 2'b00);                 // edge5
        chk("reject_cleared", 32'(signal), 32'b0101);
        repeat (4) cyc(1'b0, 2'b00);      // edges 6..9
        chk("B_freed", 32'(B), 32'd0);
        chk("hold_kept", 32'(signal), 32'b0101);
        cyc(1'b1, 2'b00);                 // edge10: slot->B, new request takes vacated slot
        chk("slot_to_B", 32'(B), 32'd1);
        chk("slot_refilled", 32'(signal), 32'b0110);

        // Random traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            else                             rst_n = 1'b1;
            cyc($urandom_range(0, 99) < 45, 2'($urandom_range(0, 3)));
        end
        rst_n = 1'b1;
        repeat (20) cyc(1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
